// File: rtl/ram_arbiter_if.sv
// Bundle of CPU-side, loader-side and RAM-side signals around the RAM arbiter.
// The slave modport is the arbiter's view; master is the environment's view.
interface ram_arbiter_if #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8
);
  logic              cpu_ren;
  logic              cpu_wen;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic [DATA_W-1:0] cpu_rdata;
  logic              cpu_stall;

  logic              ld_req;
  logic              ld_we;
  logic [ADDR_W-1:0] ld_addr;
  logic [DATA_W-1:0] ld_wdata;
  logic              ld_ack;
  logic [DATA_W-1:0] ld_rdata;

  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata;
  logic              ram_ren;
  logic              ram_wen;
  logic [DATA_W-1:0] ram_rdata;

  modport slave (
    input  cpu_ren, cpu_wen, cpu_addr, cpu_wdata,
    output cpu_rdata, cpu_stall,
    input  ld_req, ld_we, ld_addr, ld_wdata,
    output ld_ack, ld_rdata,
    output ram_addr, ram_wdata, ram_ren, ram_wen,
    input  ram_rdata
  );

  modport master (
    output cpu_ren, cpu_wen, cpu_addr, cpu_wdata,
    input  cpu_rdata, cpu_stall,
    output ld_req, ld_we, ld_addr, ld_wdata,
    input  ld_ack, ld_rdata,
    input  ram_addr, ram_wdata, ram_ren, ram_wen,
    output ram_rdata
  );
endinterface

// File: rtl/ram_arbiter.sv
// Shares the single RAM port between the CPU datapath and a program loader.
// Define RAM_ARB_LOADER_READ_EN to let loader read beats (ld_we=0) reach RAM.
module ram_arbiter #(
  parameter int ADDR_W   = 4,
  parameter int DATA_W   = 8,
  parameter int HOLD_MAX = 4
) (
  input  logic           CLK,
  input  logic           nRST,
  ram_arbiter_if.slave   bus
);

  typedef enum logic [1:0] {
    ST_CPU    = 2'd0,
    ST_LOADER = 2'd1,
    ST_YIELD  = 2'd2
  } state_t;

  localparam logic [ADDR_W:0] HOLD_LIM = (ADDR_W+1)'(HOLD_MAX);

  state_t            state;
  logic [ADDR_W-1:0] beats;
  logic              stall;

  logic              cpu_act;
  logic [ADDR_W:0]   beats_plus1;
  logic [ADDR_W-1:0] beats_sat;

  assign cpu_act     = bus.cpu_ren | bus.cpu_wen;
  assign beats_plus1 = {1'b0, beats} + {{ADDR_W{1'b0}}, 1'b1};
  assign beats_sat   = (beats_plus1 >= HOLD_LIM) ? HOLD_LIM[ADDR_W-1:0]
                                                 : beats_plus1[ADDR_W-1:0];

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state <= ST_CPU;
      beats <= '0;
      stall <= 1'b0;
    end else begin
      case (state)
        ST_CPU: begin
          // A CPU access in the same cycle as a loader request wins.
          if (bus.ld_req && !cpu_act) begin
            state <= ST_LOADER;
            beats <= '0;
            stall <= 1'b1;
          end
        end
        ST_LOADER: begin
          if (!bus.ld_req) begin
            state <= ST_CPU;
            beats <= '0;
            stall <= 1'b0;
          end else begin
            beats <= beats_sat;
            // Bound how long a stalled CPU access can wait behind a burst.
            if (cpu_act && (beats_plus1 >= HOLD_LIM)) begin
              state <= ST_YIELD;
              stall <= 1'b0;
            end
          end
        end
        ST_YIELD: begin
          state <= ST_CPU;
          beats <= '0;
          stall <= 1'b0;
        end
        default: begin
          state <= ST_CPU;
          beats <= '0;
          stall <= 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    bus.cpu_rdata = bus.ram_rdata;
    bus.cpu_stall = stall;
    bus.ld_rdata  = '0;
    if (state == ST_LOADER) begin
      bus.ram_addr  = bus.ld_addr;
      bus.ram_wdata = bus.ld_wdata;
      bus.ram_wen   = bus.ld_req & bus.ld_we & nRST;
      bus.ld_ack    = bus.ld_req;
`ifdef RAM_ARB_LOADER_READ_EN
      bus.ram_ren   = bus.ld_req & ~bus.ld_we;
      if (bus.ld_req && !bus.ld_we)
        bus.ld_rdata = bus.ram_rdata;
`else
      bus.ram_ren   = 1'b0;
`endif
    end else begin
      // Write enable is gated by reset so a beat in flight is never committed.
      bus.ram_addr  = bus.cpu_addr;
      bus.ram_wdata = bus.cpu_wdata;
      bus.ram_ren   = bus.cpu_ren;
      bus.ram_wen   = bus.cpu_wen & nRST;
      bus.ld_ack    = 1'b0;
    end
  end

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter with a behavioural 16x8 RAM attached.
module tb_ram_arbiter;
  logic clk;
  logic nrst;
  int   checks;
  int   errors;
  logic [7:0] mem [16];

  ram_arbiter_if #(.ADDR_W(4), .DATA_W(8)) bus ();

  ram_arbiter #(.ADDR_W(4), .DATA_W(8), .HOLD_MAX(4)) dut (
    .CLK  (clk),
    .nRST (nrst),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk)
    if (bus.ram_wen) mem[bus.ram_addr] <= bus.ram_wdata;
  assign bus.ram_rdata = mem[bus.ram_addr];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  logic [7:0] exp_rd;
  logic       exp_ren;

  initial begin
    checks = 0;
    errors = 0;
`ifdef RAM_ARB_LOADER_READ_EN
    exp_rd  = 8'h3A;
    exp_ren = 1'b1;
`else
    exp_rd  = 8'h00;
    exp_ren = 1'b0;
`endif

    // Reset with both requesters active.
    nrst = 1'b0;
    bus.cpu_ren = 1'b0; bus.cpu_wen = 1'b1; bus.cpu_addr = 4'd2; bus.cpu_wdata = 8'h55;
    bus.ld_req = 1'b1; bus.ld_we = 1'b1; bus.ld_addr = 4'd7; bus.ld_wdata = 8'hEE;
    #2;
    chk1("rst_ram_wen", bus.ram_wen, 1'b0);
    chk1("rst_ld_ack", bus.ld_ack, 1'b0);
    chk1("rst_stall", bus.cpu_stall, 1'b0);
    chk8("rst_ram_addr", {4'd0, bus.ram_addr}, 8'd2);
    chk8("rst_ld_rdata", bus.ld_rdata, 8'h00);
    tick();
    chk1("rst_hold_ld_ack", bus.ld_ack, 1'b0);
    chk1("rst_hold_ram_wen", bus.ram_wen, 1'b0);
    $display("step: reset held");

    // Release; CPU writes 0x55 to addr 2.
    nrst = 1'b1; bus.ld_req = 1'b0;
    #2;
    chk1("cpu_wr_wen", bus.ram_wen, 1'b1);
    tick();
    bus.cpu_addr = 4'd1; bus.cpu_wdata = 8'h77;
    tick();
    bus.cpu_wen = 1'b0;
    #2;
    chk8("cpu_wr_mem2", mem[2], 8'h55);
    chk8("cpu_wr_mem1", mem[1], 8'h77);
    $display("step: cpu writes 0x55@2, 0x77@1");

    // Loader burst: 0x3A@5, 0x0F@6 with idle CPU.
    bus.ld_req = 1'b1; bus.ld_we = 1'b1; bus.ld_addr = 4'd5; bus.ld_wdata = 8'h3A;
    #2;
    chk1("grant_cycle_ack", bus.ld_ack, 1'b0);
    chk1("grant_cycle_stall", bus.cpu_stall, 1'b0);
    tick();
    chk1("beat1_ack", bus.ld_ack, 1'b1);
    chk1("beat1_stall", bus.cpu_stall, 1'b1);
    chk1("beat1_wen", bus.ram_wen, 1'b1);
    chk8("beat1_addr", {4'd0, bus.ram_addr}, 8'd5);
    tick();
    bus.ld_addr = 4'd6; bus.ld_wdata = 8'h0F;
    #2;
    chk1("beat2_ack", bus.ld_ack, 1'b1);
    chk1("beat2_stall", bus.cpu_stall, 1'b1);
    tick();
    bus.ld_req = 1'b0;
    #2;
    chk1("drop_ack", bus.ld_ack, 1'b0);
    chk1("drop_stall", bus.cpu_stall, 1'b1);
    tick();
    chk1("after_stall", bus.cpu_stall, 1'b0);
    chk8("mem5", mem[5], 8'h3A);
    chk8("mem6", mem[6], 8'h0F);
    $display("step: loader burst 0x3A@5 0x0F@6");

    // Loader read of addr 5.
    bus.ld_req = 1'b1; bus.ld_we = 1'b0; bus.ld_addr = 4'd5;
    tick();
    chk1("rd_ack", bus.ld_ack, 1'b1);
    chk1("rd_wen", bus.ram_wen, 1'b0);
    chk1("rd_ren", bus.ram_ren, exp_ren);
    chk8("rd_data", bus.ld_rdata, exp_rd);
    tick();
    bus.ld_req = 1'b0;
    tick();
    $display("step: loader read @5");

    // Simultaneous request: CPU read of addr 2 wins.
    bus.ld_req = 1'b1; bus.ld_we = 1'b1; bus.ld_addr = 4'd9; bus.ld_wdata = 8'h11;
    bus.cpu_ren = 1'b1; bus.cpu_addr = 4'd2;
    #2;
    chk1("tie_ack", bus.ld_ack, 1'b0);
    chk1("tie_stall", bus.cpu_stall, 1'b0);
    chk1("tie_ren", bus.ram_ren, 1'b1);
    chk8("tie_rdata", bus.cpu_rdata, 8'h55);
    tick();
    bus.cpu_ren = 1'b0;
    #2;
    chk1("tie_idle_ack", bus.ld_ack, 1'b0);
    tick();
    chk1("tie_grant_ack", bus.ld_ack, 1'b1);
    chk1("tie_grant_stall", bus.cpu_stall, 1'b1);
    tick();
    bus.ld_req = 1'b0;
    tick();
    chk8("mem9", mem[9], 8'h11);
    $display("step: simultaneous cpu read and loader request");

    // Long burst with CPU read pending: 4 beats, then YIELD.
    bus.ld_req = 1'b1; bus.ld_we = 1'b1; bus.ld_addr = 4'd10; bus.ld_wdata = 8'hA0;
    tick();
    bus.cpu_ren = 1'b1; bus.cpu_addr = 4'd2;
    for (int i = 0; i < 4; i++) begin
      bus.ld_addr = 4'(10 + i); bus.ld_wdata = 8'(8'hA0 + i);
      #2;
      chk1("hold_ack", bus.ld_ack, 1'b1);
      chk1("hold_stall", bus.cpu_stall, 1'b1);
      tick();
    end
    bus.ld_addr = 4'd14; bus.ld_wdata = 8'hFF;
    #2;
    chk1("yield_ack", bus.ld_ack, 1'b0);
    chk1("yield_stall", bus.cpu_stall, 1'b0);
    chk1("yield_ren", bus.ram_ren, 1'b1);
    chk1("yield_wen", bus.ram_wen, 1'b0);
    chk8("yield_rdata", bus.cpu_rdata, 8'h55);
    tick();
    bus.cpu_ren = 1'b0;
    #2;
    chk1("post_yield_ack", bus.ld_ack, 1'b0);
    tick();
    chk1("regrant_ack", bus.ld_ack, 1'b1);
    tick();
    bus.ld_req = 1'b0;
    tick();
    chk8("mem10", mem[10], 8'hA0);
    chk8("mem13", mem[13], 8'hA3);
    chk8("mem14", mem[14], 8'hFF);
    $display("step: hold limit yield");

    // Reset during the second beat of a write burst.
    bus.ld_req = 1'b1; bus.ld_we = 1'b1; bus.ld_addr = 4'd0; bus.ld_wdata = 8'hC0;
    tick();
    chk1("mr_beat1_ack", bus.ld_ack, 1'b1);
    tick();
    bus.ld_addr = 4'd1; bus.ld_wdata = 8'hC1;
    nrst = 1'b0;
    #2;
    chk1("mr_wen", bus.ram_wen, 1'b0);
    chk1("mr_ack", bus.ld_ack, 1'b0);
    chk1("mr_stall", bus.cpu_stall, 1'b0);
    tick();
    bus.ld_req = 1'b0;
    nrst = 1'b1;
    tick();
    chk8("mr_mem0", mem[0], 8'hC0);
    chk8("mr_mem1", mem[1], 8'h77);
    chk1("mr_stall_after", bus.cpu_stall, 1'b0);
    $display("step: reset mid-burst");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
